encoder_step_scheduler: RTL and testbench

- Sequences the quadrature `Encoder` emulator. It accepts rotation commands (direction + step count) from two requesters over valid/ready handshakes.
- Arbitrates between the requesters round-robin.
- Issues one-cycle `horario`/`antihorario` request pulses to the `Encoder`, spaced far enough apart that each 4-phase A/B sequence completes before the next request.
- Sits between the control logic and the `Encoder` instance.

---
 rtl/encoder_step_scheduler.sv | 159 +++++++++++++++
 tb/tb_encoder_step_scheduler.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/encoder_step_scheduler.sv
// Round-robin command scheduler for the quadrature Encoder emulator: turns (dir, count)
// commands into one-cycle horario/antihorario pulses spaced GAP cycles apart.
module encoder_step_scheduler #(
   parameter int unsigned CNT_W = 8,
   parameter int unsigned GAP   = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   input  logic             req0_dir,
   input  logic [CNT_W-1:0] req0_count,
   output logic             req0_ready,
   input  logic             req1_valid,
   input  logic             req1_dir,
   input  logic [CNT_W-1:0] req1_count,
   output logic             req1_ready,
   input  logic             abort,
   output logic             horario,
   output logic             antihorario,
   output logic             busy,
   output logic             grant_id,
   output logic [CNT_W-1:0] steps_left,
   output logic             done
);

   if (GAP < 6) begin : g_gap_check
      $error("encoder_step_scheduler: GAP must be >= 6");
   end

   localparam int unsigned WaitW = $clog2(GAP);

   typedef enum logic [1:0] {StIdle, StPulse, StWait} state_e;

   state_e           r_state, w_state_next;
   logic             r_rr_ptr;
   logic             r_dir;
   logic             r_busy;
   logic             r_done;
   logic             r_grant;
   logic             r_abort_pend;
   logic             r_hor;
   logic             r_anti;
   logic [CNT_W-1:0] r_steps;
   logic [WaitW-1:0] r_wait;

   logic             w_idle;
   logic             w_accept;
   logic             w_winner;
   logic             w_cmd_dir;
   logic [CNT_W-1:0] w_cmd_cnt;
   logic             w_dir_eff;
   logic             w_expire;
   logic             w_more;
   logic             w_fire;
   logic             w_finish;

   // A zero-count command keeps the FSM in StIdle but holds busy for one cycle;
   // ready stays low until its done cycle.
   assign w_idle     = (r_state == StIdle) & ~r_busy & ~rst;
   assign req0_ready = w_idle & req0_valid & (~req1_valid | ~r_rr_ptr);
   assign req1_ready = w_idle & req1_valid & (~req0_valid | r_rr_ptr);
   assign w_accept   = req0_ready | req1_ready;
   assign w_winner   = req1_ready;
   assign w_cmd_dir  = w_winner ? req1_dir : req0_dir;
   assign w_cmd_cnt  = w_winner ? req1_count : req0_count;
   assign w_dir_eff  = w_accept ? w_cmd_dir : r_dir;
   assign w_expire   = (r_state == StWait) && (r_wait == '0);
   assign w_more     = (r_steps != '0) && !r_abort_pend;

   always_comb begin
      w_state_next = r_state;
      w_fire       = 1'b0;
      w_finish     = 1'b0;
      unique case (r_state)
         StIdle: begin
            if (r_busy) begin
               w_finish = 1'b1;
            end else if (w_accept && (w_cmd_cnt != '0)) begin
               w_state_next = StPulse;
               w_fire       = 1'b1;
            end
         end
         StPulse: begin
            w_state_next = StWait;
         end
         StWait: begin
            if (w_expire) begin
               if (w_more) begin
                  w_state_next = StPulse;
                  w_fire       = 1'b1;
               end else begin
                  w_state_next = StIdle;
                  w_finish     = 1'b1;
               end
            end
         end
         default: begin
            w_state_next = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= StIdle;
         r_rr_ptr     <= 1'b0;
         r_dir        <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_grant      <= 1'b0;
         r_abort_pend <= 1'b0;
         r_hor        <= 1'b0;
         r_anti       <= 1'b0;
         r_steps      <= '0;
         r_wait       <= '0;
      end else begin
         r_state <= w_state_next;
         r_hor   <= w_fire & ~w_dir_eff;
         r_anti  <= w_fire & w_dir_eff;
         r_done  <= w_finish;

         if (w_accept) begin
            r_grant  <= w_winner;
            r_rr_ptr <= ~w_winner;
            r_dir    <= w_cmd_dir;
            r_busy   <= 1'b1;
            r_steps  <= (w_cmd_cnt == '0) ? '0 : w_cmd_cnt - 1'b1;
         end else begin
            if (w_fire) begin
               r_steps <= r_steps - 1'b1;
            end
            if (w_finish) begin
               r_busy <= 1'b0;
            end
         end

         // Abort taken on the accept edge counts for the new command.
         if (w_finish) begin
            r_abort_pend <= 1'b0;
         end else if (abort && (r_busy || w_accept)) begin
            r_abort_pend <= 1'b1;
         end

         if (r_state == StPulse) begin
            r_wait <= WaitW'(GAP - 2);
         end else if ((r_state == StWait) && (r_wait != '0)) begin
            r_wait <= r_wait - 1'b1;
         end
      end
   end

   assign horario     = r_hor;
   assign antihorario = r_anti;
   assign busy        = r_busy;
   assign grant_id    = r_grant;
   assign steps_left  = r_steps;
   assign done        = r_done;

endmodule

// File: tb/tb_encoder_step_scheduler.sv
// Self-checking bench: directed literal checks plus random traffic compared every cycle
// against a timeline model of the scheduler.
module tb_encoder_step_scheduler;

   localparam int CNT_W = 8;
   localparam int GAP   = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic             req0_valid, req0_dir, req0_ready;
   logic             req1_valid, req1_dir, req1_ready;
   logic [CNT_W-1:0] req0_count, req1_count;
   logic             abort;
   logic             horario, antihorario, busy, grant_id, done;
   logic [CNT_W-1:0] steps_left;

   int checks = 0;
   int fails  = 0;

   encoder_step_scheduler #(.CNT_W(CNT_W), .GAP(GAP)) dut (
      .clk         (clk),
      .rst         (rst),
      .req0_valid  (req0_valid),
      .req0_dir    (req0_dir),
      .req0_count  (req0_count),
      .req0_ready  (req0_ready),
      .req1_valid  (req1_valid),
      .req1_dir    (req1_dir),
      .req1_count  (req1_count),
      .req1_ready  (req1_ready),
      .abort       (abort),
      .horario     (horario),
      .antihorario (antihorario),
      .busy        (busy),
      .grant_id    (grant_id),
      .steps_left  (steps_left),
      .done        (done)
   );

   always #5 clk = ~clk;

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s got=%b want=%b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chkn(input string name, input logic [CNT_W-1:0] act,
                       input logic [CNT_W-1:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s got=%0d want=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // Timeline model: a command accepted at edge e0 pulses at e0 + k*GAP while k < N and
   // no abort has been seen, and finishes at the first edge of that grid that does not pulse.
   int               t = 0;
   bit               m_busy, m_rr, m_grant, m_dir, m_abort, e_pulse, e_done;
   int               m_e0, m_n;
   logic [CNT_W-1:0] m_steps;

   task automatic m_reset();
      m_busy  = 0; m_rr = 0; m_grant = 0; m_dir = 0; m_abort = 0;
      e_pulse = 0; e_done = 0; m_steps = '0; m_n = 0; m_e0 = 0;
   endtask

   function automatic bit exp_ready(input bit me);
      bit v_me, v_other;
      v_me    = me ? req1_valid : req0_valid;
      v_other = me ? req0_valid : req1_valid;
      return !rst && !m_busy && v_me && (!v_other || (m_rr == me));
   endfunction

   initial begin : model
      bit a0, a1, fin;
      int k;
      m_reset();
      forever begin
         @(posedge clk or posedge rst);
         if (rst) begin
            m_reset();
         end else begin
            t++;
            a0 = exp_ready(1'b0);
            a1 = exp_ready(1'b1);
            e_pulse = 0;
            e_done  = 0;
            if (m_busy) begin
               fin = 0;
               if (m_n == 0) begin
                  fin = (t == m_e0 + 1);
               end else if ((t - m_e0) % GAP == 0) begin
                  k = (t - m_e0) / GAP;
                  if (k < m_n && !m_abort) begin
                     e_pulse = 1;
                     m_steps = CNT_W'(m_n - 1 - k);
                  end else begin
                     fin = 1;
                  end
               end
               if (fin) begin
                  e_done = 1; m_busy = 0; m_abort = 0;
               end else if (abort) begin
                  m_abort = 1;
               end
            end else if (a0 || a1) begin
               m_busy  = 1;
               m_e0    = t;
               m_grant = a1;
               m_rr    = !a1;
               m_dir   = a1 ? req1_dir : req0_dir;
               m_n     = int'(a1 ? req1_count : req0_count);
               m_abort = abort;
               if (m_n > 0) begin
                  e_pulse = 1;
                  m_steps = CNT_W'(m_n - 1);
               end else begin
                  m_steps = '0;
               end
            end
         end
      end
   end

   initial begin : compare
      forever begin
         @(negedge clk);
         #3;
         chk1("m_ready0", req0_ready, exp_ready(1'b0));
         chk1("m_ready1", req1_ready, exp_ready(1'b1));
         chk1("m_horario", horario, e_pulse && !m_dir);
         chk1("m_antihorario", antihorario, e_pulse && m_dir);
         chk1("m_busy", busy, m_busy);
         chk1("m_grant", grant_id, m_grant);
         chk1("m_done", done, e_done);
         chkn("m_steps", steps_left, m_steps);
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   initial begin : main
      rst = 1; abort = 0;
      req0_valid = 1; req0_dir = 0; req0_count = 8'd3;
      req1_valid = 0; req1_dir = 0; req1_count = 8'd0;

      // Reset with a pending request, then a 3-step clockwise command.
      cyc(2);
      chk1("rst_ready0", req0_ready, 1'b0);
      chk1("rst_busy", busy, 1'b0);
      chk1("rst_horario", horario, 1'b0);
      chk1("rst_done", done, 1'b0);
      chkn("rst_steps", steps_left, 8'd0);
      rst = 0;
      #1;
      chk1("post_rst_ready0", req0_ready, 1'b1);
      cyc(1);
      chk1("s_p0_hor", horario, 1'b1);
      chk1("s_p0_anti", antihorario, 1'b0);
      chk1("s_p0_busy", busy, 1'b1);
      chkn("s_p0_steps", steps_left, 8'd2);
      req0_valid = 0;
      cyc(1);
      chk1("s_gap_hor", horario, 1'b0);
      cyc(7);
      chk1("s_p1_hor", horario, 1'b1);
      chkn("s_p1_steps", steps_left, 8'd1);
      cyc(8);
      chk1("s_p2_hor", horario, 1'b1);
      chkn("s_p2_steps", steps_left, 8'd0);
      cyc(8);
      chk1("s_done", done, 1'b1);
      chk1("s_done_busy", busy, 1'b0);
      chk1("s_done_hor", horario, 1'b0);
      cyc(1);
      chk1("s_done_drop", done, 1'b0);

      // Round-robin from reset, contention, zero count.
      rst = 1;
      req0_valid = 1; req0_dir = 0; req0_count = 8'd1;
      req1_valid = 1; req1_dir = 1; req1_count = 8'd1;
      cyc(1);
      rst = 0;
      cyc(1);
      chk1("rr_grant0", grant_id, 1'b0);
      chk1("rr_hor0", horario, 1'b1);
      cyc(8);
      chk1("rr_done0", done, 1'b1);
      chk1("rr_ready1", req1_ready, 1'b1);
      chk1("rr_ready0_lost", req0_ready, 1'b0);
      cyc(1);
      chk1("rr_grant1", grant_id, 1'b1);
      chk1("rr_anti1", antihorario, 1'b1);
      req1_count = 8'd0;
      cyc(8);
      chk1("ct_done", done, 1'b1);
      chk1("ct_ready0", req0_ready, 1'b1);
      chk1("ct_ready1", req1_ready, 1'b0);
      cyc(1);
      chk1("ct_grant0", grant_id, 1'b0);
      chk1("ct_hor", horario, 1'b1);
      req0_valid = 0;
      cyc(8);
      chk1("z_ready1", req1_ready, 1'b1);
      cyc(1);
      chk1("z_grant1", grant_id, 1'b1);
      chk1("z_busy", busy, 1'b1);
      chk1("z_no_pulse", horario | antihorario, 1'b0);
      chkn("z_steps", steps_left, 8'd0);
      req1_valid = 0;
      cyc(1);
      chk1("z_done", done, 1'b1);
      chk1("z_busy_drop", busy, 1'b0);
      cyc(1);
      chk1("z_done_drop", done, 1'b0);

      // Abort three cycles after the second of five pulses.
      req0_valid = 1; req0_dir = 1; req0_count = 8'd5;
      cyc(1);
      chk1("ab_p0", antihorario, 1'b1);
      chkn("ab_p0_steps", steps_left, 8'd4);
      req0_valid = 0;
      cyc(8);
      chk1("ab_p1", antihorario, 1'b1);
      cyc(2);
      abort = 1;
      cyc(1);
      abort = 0;
      cyc(5);
      chk1("ab_done", done, 1'b1);
      chk1("ab_no_p2", antihorario, 1'b0);
      chkn("ab_steps", steps_left, 8'd3);
      chk1("ab_busy", busy, 1'b0);

      // Reset during the second WAIT of a 4-step command.
      req1_valid = 1; req1_dir = 0; req1_count = 8'd4;
      cyc(1);
      chk1("mr_p0", horario, 1'b1);
      req1_valid = 0;
      cyc(8);
      chk1("mr_p1", horario, 1'b1);
      cyc(2);
      rst = 1;
      #1;
      chk1("mr_busy", busy, 1'b0);
      chkn("mr_steps", steps_left, 8'd0);
      cyc(1);
      rst = 0;
      for (int i = 0; i < 30; i++) begin
         cyc(1);
         chk1("mr_quiet", horario | antihorario | done, 1'b0);
      end
      req0_valid = 1; req1_valid = 1;
      #1;
      chk1("mr_rr_ready0", req0_ready, 1'b1);
      chk1("mr_rr_ready1", req1_ready, 1'b0);
      cyc(1);
      req0_valid = 0; req1_valid = 0;

      // Random traffic against the model.
      for (int i = 0; i < 4000; i++) begin
         cyc(1);
         rst        = ($urandom_range(0, 299) == 0);
         req0_valid = ($urandom_range(0, 3) != 0);
         req1_valid = ($urandom_range(0, 2) == 0);
         req0_dir   = 1'($urandom_range(0, 1));
         req1_dir   = 1'($urandom_range(0, 1));
         req0_count = CNT_W'($urandom_range(0, 3));
         req1_count = CNT_W'($urandom_range(0, 4));
         abort      = ($urandom_range(0, 24) == 0);
      end
      rst = 0; abort = 0; req0_valid = 0; req1_valid = 0;
      cyc(3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
